// File: rtl/gcd_pkg.sv
// gcd_pkg
//   Shared definitions for the GCD job scheduler slice.
//   - gcd_state_e       : scheduler FSM encoding (3 bits)
//   - GCD_WIDTH_DEFAULT : default operand/result width
//   - gcd_has_zero      : true when either operand is zero (bypass condition)
package gcd_pkg;

  localparam int GCD_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    LOADA = 3'd2,
    LOADB = 3'd3,
    WAIT  = 3'd4,
    CLEAR = 3'd5
  } gcd_state_e;

  // Zero operands must never reach the core: its subtract loop never ends.
  function automatic logic gcd_has_zero(input logic [GCD_WIDTH_DEFAULT-1:0] a,
                                        input logic [GCD_WIDTH_DEFAULT-1:0] b);
    return (a == '0) || (b == '0);
  endfunction

endpackage

// File: rtl/gcd_watchdog.sv
// gcd_watchdog
//   Loadable down-counter with an expire flag. Only built when the macro
//   GCD_TIMEOUT_EN is defined; the default build has no watchdog at all.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   load_i          : load cnt with load_val_i (takes priority over dec_i)
//   load_val_i      : value loaded on load_i
//   dec_i           : decrement by one, saturating at zero
//   expired_o       : counter is zero
`ifdef GCD_TIMEOUT_EN
module gcd_watchdog #(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          expired_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`endif

// File: rtl/gcd_job_scheduler.sv
// gcd_job_scheduler
//   Upstream sequencer for the GCD core. Accepts operand pairs on a
//   valid/ready stream, drives the core's start / A-load / B-load cycles,
//   captures the result into a one-entry output register and clears the
//   core between jobs. Pairs with a zero operand bypass the core.
//   Optional watchdog: define GCD_TIMEOUT_EN to abort a job that stays in
//   WAIT for TIMEOUT cycles (out_err=1, out_gcd=0).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
//   both high; the producer holds data stable while valid && !ready, and
//   ready never depends combinationally on valid.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand stream handshake; in_a, in_b operands
//   out_valid/out_ready : result register handshake
//   out_gcd, out_zero, out_err : result, both-zero flag, watchdog abort flag
//   core_start          : one-cycle start pulse to the core
//   core_din            : operand bus (A during LOADA, B from LOADB onward)
//   core_clear          : registered core reset (high in reset and CLEAR)
//   core_done, core_result : core status and its A register
//   dbg_state           : current FSM state for observation
module gcd_job_scheduler
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_WIDTH_DEFAULT,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_zero,
  output logic             out_err,
  output logic             core_start,
  output logic [WIDTH-1:0] core_din,
  output logic             core_clear,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output gcd_state_e       dbg_state
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_gcd_q, out_gcd_d;
  logic             out_zero_q, out_zero_d;
  logic             out_err_q, out_err_d;
  logic             core_clear_q;
  logic             accept;
  logic             in_zero;
  logic             wd_expired;

  // A pending result blocks acceptance, so a drain and a new accept never
  // share an edge.
  assign in_ready = (state_q == IDLE) && !out_valid_q && !reset;
  assign accept   = in_valid && in_ready;
  assign in_zero  = (in_a == '0) || (in_b == '0);

`ifdef GCD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic wd_zero;

  // Loaded in LOADB so the first WAIT cycle sees TIMEOUT-1; expiry then
  // lands on the TIMEOUT-th edge spent in WAIT.
  gcd_watchdog #(.CW(CW)) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .load_i     (state_q == LOADB),
    .load_val_i (CW'(TIMEOUT - 1)),
    .dec_i      (state_q == WAIT),
    .expired_o  (wd_zero)
  );
  assign wd_expired = (state_q == WAIT) && wd_zero;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign wd_expired     = 1'b0;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      out_valid_q  <= 1'b0;
      out_gcd_q    <= '0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
      core_clear_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      out_valid_q  <= out_valid_d;
      out_gcd_q    <= out_gcd_d;
      out_zero_q   <= out_zero_d;
      out_err_q    <= out_err_d;
      core_clear_q <= (state_d == CLEAR);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept && !in_zero) state_d = START;
      START: state_d = LOADA;
      LOADA: state_d = LOADB;
      LOADB: state_d = WAIT;
      WAIT:  if (core_done || wd_expired) state_d = CLEAR;
      CLEAR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and result register.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    out_valid_d = out_valid_q;
    out_gcd_d   = out_gcd_q;
    out_zero_d  = out_zero_q;
    out_err_d   = out_err_q;

    if (accept) begin
      a_d = in_a;
      b_d = in_b;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_zero_d  = 1'b0;
      out_err_d   = 1'b0;
    end

    // Bypass: the OR of the operands is the nonzero one, or 0 if both are.
    if (accept && in_zero) begin
      out_valid_d = 1'b1;
      out_gcd_d   = in_a | in_b;
      out_zero_d  = (in_a == '0) && (in_b == '0);
      out_err_d   = 1'b0;
    end

    if ((state_q == WAIT) && core_done) begin
      out_valid_d = 1'b1;
      out_gcd_d   = core_result;
      out_zero_d  = 1'b0;
      out_err_d   = 1'b0;
    end else if (wd_expired) begin
      out_valid_d = 1'b1;
      out_gcd_d   = '0;
      out_zero_d  = 1'b0;
      out_err_d   = 1'b1;
    end
  end

  // Core-facing outputs decoded from state.
  always_comb begin
    core_start = (state_q == START);
    core_din   = '0;
    case (state_q)
      LOADA:      core_din = a_q;
      LOADB, WAIT: core_din = b_q;
      default:    core_din = '0;
    endcase
  end

  assign out_valid  = out_valid_q;
  assign out_gcd    = out_gcd_q;
  assign out_zero   = out_zero_q;
  assign out_err    = out_err_q;
  assign core_clear = core_clear_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/gcd_job_scheduler.md
# gcd_job_scheduler

Upstream sequencer for the GCD core (controller plus datapath). Accepts operand pairs on a valid/ready stream and sequences the core's start, A-load and B-load cycles. Captures the core result into a one-entry output register and clears the core between jobs. Zero operands never reach the core, because its subtract loop does not terminate on them.

## Interface
Parameters:
- WIDTH, 16, operand and result width
- TIMEOUT, 1024, watchdog limit in cycles (used only with GCD_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  scheduler can accept a pair
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  result register full
- out_ready  in  1  consumer takes result
- out_gcd  out  WIDTH  result
- out_zero  out  1  both operands were zero
- out_err  out  1  job aborted by watchdog
- core_start  out  1  start pulse to core
- core_din  out  WIDTH  operand bus to core datapath
- core_clear  out  1  core reset, registered
- core_done  in  1  core in DONE state
- core_result  in  WIDTH  core A register (GCD when done)

## Operation
- Reset values:
  - state IDLE
  - in_ready 0 while reset is asserted
  - out_valid, out_gcd, out_zero, out_err, core_start 0
  - core_din 0
  - core_clear 1, which holds the core in reset; it drops on the first clk edge after reset release.
- in_ready = (state==IDLE) && !out_valid. A job is accepted on an edge where in_valid && in_ready; A and B are registered.
- States:
  - IDLE: on accept, if in_a==0 or in_b==0, take the bypass (stay in IDLE). Otherwise go to START.
  - START: core_start=1 for exactly one cycle, then LOADA.
  - LOADA: core_din=A, then LOADB.
  - LOADB: core_din=B, then WAIT.
  - WAIT: core_din holds B. When core_done=1, load out_gcd from core_result, set out_valid=1, then CLEAR.
  - CLEAR: core_clear=1 for one cycle, then IDLE.
- Bypass result, loaded on the accept edge:
  - out_gcd = in_a | in_b, i.e. the nonzero operand, or 0 when both are zero
  - out_zero = (in_a==0 && in_b==0)
  - out_valid set on the same edge
- Output: out_valid clears on the edge where out_valid && out_ready. out_gcd, out_zero and out_err are stable while out_valid=1.
- Arithmetic: no arithmetic in this block; widths of in_a, in_b, out_gcd, core_din and core_result are all WIDTH.
- Reset mid-job: state returns to IDLE and any pending result is discarded. core_clear is asserted, so the core also returns to its idle state.
- A job is never accepted while a result is pending. Simultaneous out_ready and in_valid in IDLE therefore: the result drains on that edge and the new job is accepted on the next edge.

## Timing
- Accept at edge 0. Then:
  - START during cycle 0→1
  - LOADA during cycle 1→2, matching the core's LOADA cycle
  - LOADB during cycle 2→3
  - WAIT from cycle 3
- Done to result: out_valid rises on the first edge with core_done=1 in WAIT. CLEAR follows for one cycle. in_ready cannot rise again before out_valid falls.
- Bypass latency: out_valid is high 1 cycle after the accept edge.
- Minimum spacing between core jobs: 6 cycles plus the core's compute time.

## Configuration
- GCD_TIMEOUT_EN defined:
  - A cycle counter resets on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT without core_done: out_gcd=0, out_err=1, out_valid=1, then CLEAR.
  - out_err clears when the result is consumed.
- Not defined: no counter; WAIT lasts until core_done; out_err is tied 0.

## Structure
- Package gcd_pkg:
  - state enum, 3 bits: IDLE, START, LOADA, LOADB, WAIT, CLEAR
  - GCD_WIDTH_DEFAULT constant
- Sub-module gcd_watchdog: a loadable down-counter with an expire flag, instantiated only under GCD_TIMEOUT_EN.

## Test plan
- (48,18) with out_ready=1 → core_start pulses once; core_din shows 48 then 18 on consecutive cycles; out_gcd=6, out_zero=0; core_clear pulses once.
- (0,35) → no core_start; out_valid 1 cycle after accept; out_gcd=35. (21,0) → out_gcd=21.
- (0,0) → out_gcd=0, out_zero=1, core untouched.
- (17,5) with out_ready=0 for 10 cycles → out_gcd=1 is held stable and in_ready stays 0. Raising out_ready drains the result; a queued (9,6) then yields 3.
- Assert reset during WAIT of (1000,3) → all outputs return to reset values and core_clear=1. After release, (12,8) → 4.
- GCD_TIMEOUT_EN with TIMEOUT=20 and core_done forced 0 → out_err=1, out_gcd=0, out_valid 20 cycles after WAIT entry.
